// File: rtl/uart_cmd_engine.sv
// uart_cmd_engine
// ---------------------------------------------------------------------------
// Host command engine between the UART RX/TX byte cores and the APU/audio
// subsystems. Parses framed commands byte by byte, pulses subsystem resets,
// streams bursts into / out of APU RAM and answers each frame with a status
// byte (followed by read data or the version byte where applicable).
//
// Commands: 0x01 AUDIO_RESET, 0x22 APU_RESET, 0x10 WRITE_RAM, 0x11 READ_RAM,
//           0x30 PING. Status: 0x00 ok, 0xFE timeout, 0xFF unknown command,
//           0xFC checksum mismatch (checksum build only).
//
// Optional feature: define UART_CMD_CHECKSUM_EN to require a trailing XOR
// checksum byte on WRITE_RAM frames.
//
// Ports:
//   clock_i        system clock
//   reset_n_i      asynchronous active-low reset
//   rx_byte_i      received byte, qualified by rx_valid_i (1-cycle strobe)
//   tx_idle_i      TX core ready for a byte
//   tx_byte_o      byte to send, qualified by tx_valid_o (1-cycle strobe)
//   apu_reset_o    APU reset pulse (PULSE_CYCLES clocks)
//   audio_reset_o  audio reset pulse (PULSE_CYCLES clocks)
//   ram_address_o  RAM address (8*ADDR_BYTES bits)
//   ram_wdata_o    RAM write data, qualified by ram_we_o (1-cycle strobe)
//   ram_re_o       RAM read strobe; ram_rdata_i valid RAM_READ_LATENCY later
//   busy_o         high whenever the engine is not idle
// ---------------------------------------------------------------------------
module uart_cmd_engine #(
  parameter int ADDR_BYTES       = 2,
  parameter int LEN_BYTES        = 1,
  parameter int TIMEOUT_CYCLES   = 480,
  parameter int PULSE_CYCLES     = 512,
  parameter int RAM_READ_LATENCY = 1,
  parameter int TX_GUARD         = 2
) (
  input  logic                    clock_i,
  input  logic                    reset_n_i,
  input  logic [7:0]              rx_byte_i,
  input  logic                    rx_valid_i,
  input  logic                    tx_idle_i,
  output logic [7:0]              tx_byte_o,
  output logic                    tx_valid_o,
  output logic                    apu_reset_o,
  output logic                    audio_reset_o,
  output logic [8*ADDR_BYTES-1:0] ram_address_o,
  output logic [7:0]              ram_wdata_o,
  output logic                    ram_we_o,
  output logic                    ram_re_o,
  input  logic [7:0]              ram_rdata_i,
  output logic                    busy_o
);

  localparam int AW        = 8 * ADDR_BYTES;
  localparam int LW        = 8 * LEN_BYTES;
  localparam int HDR_BYTES = ADDR_BYTES + LEN_BYTES;
  localparam int TOW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PCW       = $clog2(PULSE_CYCLES + 1);
  localparam int LTW       = $clog2(RAM_READ_LATENCY + 1);
  localparam int GW        = (TX_GUARD > 0) ? $clog2(TX_GUARD + 1) : 1;

  localparam logic [7:0] CMD_AUDIO_RESET = 8'h01;
  localparam logic [7:0] CMD_APU_RESET   = 8'h22;
  localparam logic [7:0] CMD_WRITE_RAM   = 8'h10;
  localparam logic [7:0] CMD_READ_RAM    = 8'h11;
  localparam logic [7:0] CMD_PING        = 8'h30;

  localparam logic [7:0] ST_OK       = 8'h00;
  localparam logic [7:0] ST_TIMEOUT  = 8'hFE;
  localparam logic [7:0] ST_UNKNOWN  = 8'hFF;
  localparam logic [7:0] VERSION     = 8'hA5;

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_WRITE, S_CKSUM, S_READ_ISSUE, S_READ_WAIT,
    S_READ_SEND, S_PULSE, S_REPLY, S_DRAIN
  } state_e;

  // What follows once the reply byte in S_REPLY has been handed to TX.
  typedef enum logic [1:0] {POST_DRAIN, POST_READ, POST_VERSION} post_e;

  state_e          state_q;
  post_e           post_q;
  logic [7:0]      cmd_q;
  logic [AW-1:0]   addr_q;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   rem_q;        // bytes left after the current one
  logic [2:0]      hdr_cnt_q;
  logic [TOW-1:0]  to_cnt_q;
  logic [PCW-1:0]  pulse_cnt_q;
  logic [LTW-1:0]  lat_cnt_q;
  logic [GW-1:0]   guard_q;
  logic [7:0]      reply_q;
  logic [7:0]      rdata_q;
`ifdef UART_CMD_CHECKSUM_EN
  logic [7:0]      cks_q;
`endif

  logic [7:0]      tx_byte_q;
  logic            tx_valid_q;
  logic            apu_reset_q;
  logic            audio_reset_q;
  logic [AW-1:0]   ram_address_q;
  logic [7:0]      ram_wdata_q;
  logic            ram_we_q;
  logic            ram_re_q;
  logic            busy_q;

  // Header fields are shifted in MSB first.
  logic [AW-1:0]   addr_shift_d;
  logic [LW-1:0]   len_shift_d;
  logic            in_frame_d;
  logic            to_expired_d;
  logic            send_d;
  logic [7:0]      tx_data_d;

  always_comb begin
    addr_shift_d = (addr_q << 8) | AW'(rx_byte_i);
    len_shift_d  = (len_q << 8) | LW'(rx_byte_i);
    in_frame_d   = (state_q == S_HDR) || (state_q == S_WRITE) || (state_q == S_CKSUM);
    to_expired_d = (to_cnt_q == TOW'(TIMEOUT_CYCLES - 1));
    // A byte may go out only once the TX core is idle and the guard window
    // after the previous strobe (TX core idle-flag latency) has passed.
    send_d       = tx_idle_i && (guard_q == '0) && !tx_valid_q &&
                   ((state_q == S_REPLY) || (state_q == S_READ_SEND));
    tx_data_d    = (state_q == S_REPLY) ? reply_q : rdata_q;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= S_IDLE;
      post_q        <= POST_DRAIN;
      cmd_q         <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      rem_q         <= '0;
      hdr_cnt_q     <= '0;
      to_cnt_q      <= '0;
      pulse_cnt_q   <= '0;
      lat_cnt_q     <= '0;
      guard_q       <= '0;
      reply_q       <= '0;
      rdata_q       <= '0;
`ifdef UART_CMD_CHECKSUM_EN
      cks_q         <= '0;
`endif
      tx_byte_q     <= '0;
      tx_valid_q    <= 1'b0;
      apu_reset_q   <= 1'b0;
      audio_reset_q <= 1'b0;
      ram_address_q <= '0;
      ram_wdata_q   <= '0;
      ram_we_q      <= 1'b0;
      ram_re_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      // Strobes default low; TX handshake is shared by REPLY and READ_SEND.
      ram_we_q   <= 1'b0;
      ram_re_q   <= 1'b0;
      tx_valid_q <= send_d;
      if (send_d) begin
        tx_byte_q <= tx_data_d;
        guard_q   <= GW'(TX_GUARD);
      end else if (guard_q != '0) begin
        guard_q <= guard_q - 1'b1;
      end

      // Inter-byte timeout only runs inside a host frame.
      if (in_frame_d && !rx_valid_i) to_cnt_q <= to_cnt_q + 1'b1;
      else                           to_cnt_q <= '0;

      unique case (state_q)
        S_IDLE: begin
          if (rx_valid_i) begin
            cmd_q     <= rx_byte_i;
            busy_q    <= 1'b1;
            hdr_cnt_q <= '0;
            post_q    <= POST_DRAIN;
`ifdef UART_CMD_CHECKSUM_EN
            cks_q     <= rx_byte_i;
`endif
            case (rx_byte_i)
              CMD_AUDIO_RESET: begin
                audio_reset_q <= 1'b1;
                pulse_cnt_q   <= '0;
                state_q       <= S_PULSE;
              end
              CMD_APU_RESET: begin
                apu_reset_q <= 1'b1;
                pulse_cnt_q <= '0;
                state_q     <= S_PULSE;
              end
              CMD_WRITE_RAM, CMD_READ_RAM: state_q <= S_HDR;
              CMD_PING: begin
                reply_q <= ST_OK;
                post_q  <= POST_VERSION;
                state_q <= S_REPLY;
              end
              default: begin
                reply_q <= ST_UNKNOWN;
                state_q <= S_REPLY;
              end
            endcase
          end
        end

        S_HDR: begin
          if (rx_valid_i) begin
`ifdef UART_CMD_CHECKSUM_EN
            cks_q <= cks_q ^ rx_byte_i;
`endif
            hdr_cnt_q <= hdr_cnt_q + 1'b1;
            if (hdr_cnt_q < 3'(ADDR_BYTES)) addr_q <= addr_shift_d;
            else                            len_q  <= len_shift_d;
            // The final header byte is always the low length byte.
            if (hdr_cnt_q == 3'(HDR_BYTES - 1)) begin
              rem_q <= len_shift_d;
              if (cmd_q == CMD_WRITE_RAM) begin
                state_q <= S_WRITE;
              end else begin
                reply_q <= ST_OK;
                post_q  <= POST_READ;
                state_q <= S_REPLY;
              end
            end
          end else if (to_expired_d) begin
            reply_q <= ST_TIMEOUT;
            state_q <= S_REPLY;
          end
        end

        S_WRITE: begin
          if (rx_valid_i) begin
            ram_we_q      <= 1'b1;
            ram_wdata_q   <= rx_byte_i;
            ram_address_q <= addr_q;
            addr_q        <= addr_q + 1'b1;
`ifdef UART_CMD_CHECKSUM_EN
            cks_q         <= cks_q ^ rx_byte_i;
`endif
            if (rem_q == '0) begin
`ifdef UART_CMD_CHECKSUM_EN
              state_q <= S_CKSUM;
`else
              reply_q <= ST_OK;
              state_q <= S_REPLY;
`endif
            end else begin
              rem_q <= rem_q - 1'b1;
            end
          end else if (to_expired_d) begin
            reply_q <= ST_TIMEOUT;
            state_q <= S_REPLY;
          end
        end

`ifdef UART_CMD_CHECKSUM_EN
        S_CKSUM: begin
          if (rx_valid_i) begin
            reply_q <= (rx_byte_i == cks_q) ? ST_OK : 8'hFC;
            state_q <= S_REPLY;
          end else if (to_expired_d) begin
            reply_q <= ST_TIMEOUT;
            state_q <= S_REPLY;
          end
        end
`endif

        S_PULSE: begin
          if (pulse_cnt_q == PCW'(PULSE_CYCLES - 1)) begin
            apu_reset_q   <= 1'b0;
            audio_reset_q <= 1'b0;
            reply_q       <= ST_OK;
            state_q       <= S_REPLY;
          end else begin
            pulse_cnt_q <= pulse_cnt_q + 1'b1;
          end
        end

        S_REPLY: begin
          if (send_d) begin
            case (post_q)
              POST_READ:    state_q <= S_READ_ISSUE;
              POST_VERSION: begin
                reply_q <= VERSION;
                post_q  <= POST_DRAIN;
              end
              default:      state_q <= S_DRAIN;
            endcase
          end
        end

        S_READ_ISSUE: begin
          ram_re_q      <= 1'b1;
          ram_address_q <= addr_q;
          addr_q        <= addr_q + 1'b1;
          lat_cnt_q     <= '0;
          state_q       <= S_READ_WAIT;
        end

        // ram_re_q is visible one clock after issue, so data is sampled
        // RAM_READ_LATENCY+1 edges after the issue edge.
        S_READ_WAIT: begin
          if (lat_cnt_q == LTW'(RAM_READ_LATENCY)) begin
            rdata_q <= ram_rdata_i;
            state_q <= S_READ_SEND;
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end

        S_READ_SEND: begin
          if (send_d) begin
            if (rem_q == '0) begin
              state_q <= S_DRAIN;
            end else begin
              rem_q   <= rem_q - 1'b1;
              state_q <= S_READ_ISSUE;
            end
          end
        end

        S_DRAIN: begin
          ram_address_q <= '0;
          busy_q        <= 1'b0;
          state_q       <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_byte_o     = tx_byte_q;
  assign tx_valid_o    = tx_valid_q;
  assign apu_reset_o   = apu_reset_q;
  assign audio_reset_o = audio_reset_q;
  assign ram_address_o = ram_address_q;
  assign ram_wdata_o   = ram_wdata_q;
  assign ram_we_o      = ram_we_q;
  assign ram_re_o      = ram_re_q;
  assign busy_o        = busy_q;

endmodule
